// File: rtl/fugue_host_if_if.sv
// Host and core bus bundles for the Fugue host responder.
// Latency: none (wiring only).
// Backpressure: host side via ack pulses; core side via core_wready.
//
// fugue_host_bus_if : init/load/fetch/idata from host, ack/odata/err back.
// fugue_core_bus_if : packed message words and control to the hash core,
//                     digest and done level back from it.

interface fugue_host_bus_if #(
  parameter int IOSIZE = 16
);
  logic              init;
  logic              load;
  logic              fetch;
  logic [IOSIZE-1:0] idata;
  logic              ack;
  logic [IOSIZE-1:0] odata;
  logic              err;

  modport master (output init, load, fetch, idata, input ack, odata, err);
  modport slave  (input init, load, fetch, idata, output ack, odata, err);
endinterface

interface fugue_core_bus_if #(
  parameter int WORDSIZE     = 32,
  parameter int DIGEST_WORDS = 8
);
  logic                             core_init;
  logic                             core_wvalid;
  logic [WORDSIZE-1:0]              core_wdata;
  logic                             core_wready;
  logic                             core_final;
  logic                             core_done;
  logic [WORDSIZE*DIGEST_WORDS-1:0] core_digest;

  modport master (output core_init, core_wvalid, core_wdata, core_final,
                  input  core_wready, core_done, core_digest);
  modport slave  (input  core_init, core_wvalid, core_wdata, core_final,
                  output core_wready, core_done, core_digest);
endinterface

// File: rtl/fugue_host_if.sv
// Host responder: packs 16-bit host halfwords into 32-bit core words and streams the digest back.
// Latency: ack 1 cycle after acceptance (low half: 1 cycle after core_wready; first digest halfword: 1 cycle after core_done).
// Backpressure: low-half ack withheld until the core takes the word; a held request is accepted at most every other cycle.
//
// Ports: clk, rst (sync, active high);
//        host : init/load/fetch/idata in, ack/odata/err out (all outputs registered)
//        core : core_init/core_wvalid/core_wdata/core_final out, core_wready/core_done/core_digest in

module fugue_host_if #(
  parameter int IOSIZE       = 16,
  parameter int WORDSIZE     = 32,
  parameter int DIGEST_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  fugue_host_bus_if.slave  host,
  fugue_core_bus_if.master core
);

  localparam int DW     = WORDSIZE * DIGEST_WORDS;
  localparam int HW_CNT = DW / IOSIZE;
  localparam int CW     = $clog2(HW_CNT);
  localparam logic [CW-1:0] LAST_HW = CW'(HW_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    PUSH,
    FINAL,
    DRAIN
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic                r_ack,    w_ack_nxt;
  logic                r_err,    w_err_nxt;
  logic                r_cinit,  w_cinit_nxt;
  logic                r_cfinal, w_cfinal_nxt;
  logic                r_wvalid, w_wvalid_nxt;
  logic [WORDSIZE-1:0] r_wdata,  w_wdata_nxt;
  logic [IOSIZE-1:0]   r_odata,  w_odata_nxt;
  logic [IOSIZE-1:0]   r_buf_hi, w_buf_hi_nxt;
  logic [CW-1:0]       r_fcnt,   w_fcnt_nxt;

  logic                w_load_acc;
  logic                w_fetch_acc;
  logic [DW-1:0]       w_dig_shift;
  logic [IOSIZE-1:0]   w_dig_hw;

  // ack is registered, so gating on it makes a held request count once per ack.
  assign w_load_acc  = host.load  && !r_ack;
  assign w_fetch_acc = host.fetch && !r_ack;

  // Halfword r_fcnt of the digest, most significant halfword first.
  assign w_dig_shift = core.core_digest << (32'(r_fcnt) * IOSIZE);
  assign w_dig_hw    = w_dig_shift[DW-1 -: IOSIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_cinit  <= 1'b0;
      r_cfinal <= 1'b0;
      r_wvalid <= 1'b0;
      r_wdata  <= '0;
      r_odata  <= '0;
      r_buf_hi <= '0;
      r_fcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_cinit  <= w_cinit_nxt;
      r_cfinal <= w_cfinal_nxt;
      r_wvalid <= w_wvalid_nxt;
      r_wdata  <= w_wdata_nxt;
      r_odata  <= w_odata_nxt;
      r_buf_hi <= w_buf_hi_nxt;
      r_fcnt   <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_cinit_nxt  = 1'b0;
    w_cfinal_nxt = 1'b0;
    w_wvalid_nxt = r_wvalid;
    w_wdata_nxt  = r_wdata;
    w_odata_nxt  = r_odata;
    w_buf_hi_nxt = r_buf_hi;
    w_fcnt_nxt   = r_fcnt;

    if (host.init) begin
      // init wins in every state; an in-flight word is abandoned.
      w_cinit_nxt  = 1'b1;
      w_wvalid_nxt = 1'b0;
      w_buf_hi_nxt = '0;
      w_fcnt_nxt   = '0;
      w_state_nxt  = LOAD_HI;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load_acc || w_fetch_acc) w_err_nxt = 1'b1;
        end
        LOAD_HI: begin
          if (w_load_acc && w_fetch_acc) begin
            w_err_nxt = 1'b1;
          end else if (w_load_acc) begin
            w_buf_hi_nxt = host.idata;
            w_ack_nxt    = 1'b1;
            w_state_nxt  = LOAD_LO;
          end else if (w_fetch_acc) begin
            // Pulse core_final on the transition so it fires once per entry.
            w_cfinal_nxt = 1'b1;
            w_state_nxt  = FINAL;
          end
        end
        LOAD_LO: begin
          if (w_load_acc && w_fetch_acc) begin
            w_err_nxt = 1'b1;
          end else if (w_load_acc) begin
            w_wdata_nxt  = {r_buf_hi, host.idata};
            w_wvalid_nxt = 1'b1;
            w_state_nxt  = PUSH;
          end else if (w_fetch_acc) begin
            // Odd halfword count cannot form a whole word.
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        PUSH: begin
          if (core.core_wready) begin
            w_wvalid_nxt = 1'b0;
            w_ack_nxt    = 1'b1;
            w_state_nxt  = LOAD_HI;
          end
        end
        FINAL: begin
          if (core.core_done) begin
            w_odata_nxt = core.core_digest[DW-1 -: IOSIZE];
            w_ack_nxt   = 1'b1;
            w_fcnt_nxt  = CW'(1);
            w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (w_load_acc) begin
            w_err_nxt = 1'b1;
          end else if (w_fetch_acc) begin
            w_odata_nxt = w_dig_hw;
            w_ack_nxt   = 1'b1;
            w_fcnt_nxt  = r_fcnt + CW'(1);
            if (r_fcnt == LAST_HW) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign host.ack         = r_ack;
  assign host.err         = r_err;
  assign host.odata       = r_odata;
  assign core.core_init   = r_cinit;
  assign core.core_final  = r_cfinal;
  assign core.core_wvalid = r_wvalid;
  assign core.core_wdata  = r_wdata;

endmodule

// File: tb/tb_fugue_host_if.sv
module tb_fugue_host_if;

  logic clk;
  logic rst;

  fugue_host_bus_if #(.IOSIZE(16)) hbus ();
  fugue_core_bus_if #(.WORDSIZE(32), .DIGEST_WORDS(8)) cbus ();

  fugue_host_if #(.IOSIZE(16), .WORDSIZE(32), .DIGEST_WORDS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (hbus),
    .core (cbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_err = 0;
  int n_final = 0;
  int exp_err = 0;
  int exp_final = 0;
  logic [31:0] got_words[$];
  logic [31:0] exp_words[$];
  logic [15:0] exp_hw[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs observed 2ns after the edge. A word counts as taken
  // by the core if valid and ready were both high going into the edge.
  task automatic step();
    logic pv, pr;
    logic [31:0] pd;
    pv = cbus.core_wvalid;
    pr = cbus.core_wready;
    pd = cbus.core_wdata;
    @(posedge clk);
    #2;
    if (pv === 1'b1 && pr === 1'b1) got_words.push_back(pd);
    if (hbus.err === 1'b1) n_err++;
    if (cbus.core_final === 1'b1) n_final++;
  endtask

  // Reference digest: halfword k is exp_hw[k], packed MS-first.
  task automatic set_digest(input bit counting);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) begin
      exp_hw[k] = counting ? 16'(k + 1) : 16'($urandom);
      d = {d[239:0], exp_hw[k]};
    end
    cbus.core_digest = d;
  endtask

  task automatic host_init();
    cbus.core_done = 1'b0;
    hbus.init = 1'b1;
    step();
    check("init_pulse", 32'(cbus.core_init), 1);
    check("init_noack", 32'(hbus.ack), 0);
    hbus.init = 1'b0;
    step();
    check("init_once", 32'(cbus.core_init), 0);
  endtask

  task automatic load_word(input logic [15:0] hi, input logic [15:0] lo, input int dly);
    bit got;
    got = 0;
    hbus.idata = hi;
    hbus.load = 1'b1;
    for (int c = 0; c < 4 && !got; c++) begin
      step();
      if (hbus.ack === 1'b1) got = 1;
    end
    check("load_hi_ack", 32'(got), 1);
    hbus.load = 1'b0;
    step();
    hbus.idata = lo;
    hbus.load = 1'b1;
    got = 0;
    for (int c = 0; c < 4 && !got; c++) begin
      step();
      if (cbus.core_wvalid === 1'b1) got = 1;
    end
    check("wvalid_up", 32'(got), 1);
    check("wdata", cbus.core_wdata, {hi, lo});
    check("lo_noack", 32'(hbus.ack), 0);
    for (int i = 0; i < dly; i++) begin
      step();
      check("stall_wvalid", 32'(cbus.core_wvalid), 1);
      check("stall_wdata", cbus.core_wdata, {hi, lo});
      check("stall_noack", 32'(hbus.ack), 0);
    end
    cbus.core_wready = 1'b1;
    step();
    check("push_ack", 32'(hbus.ack), 1);
    check("push_drop", 32'(cbus.core_wvalid), 0);
    cbus.core_wready = 1'b0;
    hbus.load = 1'b0;
    exp_words.push_back({hi, lo});
    step();
  endtask

  // Requests halfword k; the core model raises done 3 cycles after core_final.
  task automatic fetch_hw(input int k);
    bit got;
    int cd;
    got = 0;
    cd = -1;
    hbus.fetch = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (cbus.core_final === 1'b1) cd = 3;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) cbus.core_done = 1'b1;
      end
      if (hbus.ack === 1'b1) got = 1;
    end
    check("fetch_ack", 32'(got), 1);
    hbus.fetch = 1'b0;
    check("odata", 32'(hbus.odata), 32'(exp_hw[k]));
    step();
    check("odata_hold", 32'(hbus.odata), 32'(exp_hw[k]));
    check("ack_single", 32'(hbus.ack), 0);
  endtask

  task automatic bad_req(input bit is_load);
    if (is_load) hbus.load = 1'b1;
    else hbus.fetch = 1'b1;
    step();
    check(is_load ? "bad_load_err" : "bad_fetch_err", 32'(hbus.err), 1);
    check("bad_noack", 32'(hbus.ack), 0);
    hbus.load = 1'b0;
    hbus.fetch = 1'b0;
    exp_err++;
    step();
  endtask

  initial begin
    rst = 1'b1;
    hbus.init = 1'b0;
    hbus.load = 1'b0;
    hbus.fetch = 1'b0;
    hbus.idata = '0;
    cbus.core_wready = 1'b0;
    cbus.core_done = 1'b0;
    cbus.core_digest = '0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_ack", 32'(hbus.ack), 0);
    check("rst_err", 32'(hbus.err), 0);
    check("rst_odata", 32'(hbus.odata), 0);
    check("rst_cinit", 32'(cbus.core_init), 0);
    check("rst_wvalid", 32'(cbus.core_wvalid), 0);
    check("rst_wdata", cbus.core_wdata, 0);
    check("rst_final", 32'(cbus.core_final), 0);
    rst = 1'b0;

    // Two words, second one stalled 5 cycles, then the counting digest.
    host_init();
    load_word(16'h0123, 16'h4567, 0);
    load_word(16'($urandom), 16'($urandom), 5);
    check("no_err_loads", 32'(n_err), 0);
    set_digest(1);
    for (int k = 0; k < 16; k++) fetch_hw(k);
    exp_final++;
    check("final_count", 32'(n_final), 32'(exp_final));
    bad_req(1);

    // Odd halfword count.
    host_init();
    hbus.idata = 16'hAAAA;
    hbus.load = 1'b1;
    step();
    check("odd_hi_ack", 32'(hbus.ack), 1);
    hbus.load = 1'b0;
    step();
    bad_req(0);
    check("odd_no_final", 32'(n_final), 32'(exp_final));
    bad_req(1);

    // Random messages; zero-length first, init mid-drain on the third.
    for (int m = 0; m < 4; m++) begin
      int nw;
      host_init();
      if (m == 1) begin
        hbus.load = 1'b1;
        hbus.fetch = 1'b1;
        step();
        check("both_err", 32'(hbus.err), 1);
        check("both_noack", 32'(hbus.ack), 0);
        exp_err++;
        hbus.load = 1'b0;
        hbus.fetch = 1'b0;
        step();
      end
      nw = (m == 0) ? 0 : $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        load_word(16'($urandom), 16'($urandom), $urandom_range(0, 3));
      set_digest(0);
      if (m == 2) begin
        for (int k = 0; k < 4; k++) fetch_hw(k);
        exp_final++;
        bad_req(1);
        host_init();
        load_word(16'($urandom), 16'($urandom), 1);
        set_digest(0);
      end
      for (int k = 0; k < 16; k++) fetch_hw(k);
      exp_final++;
      check("final_count_m", 32'(n_final), 32'(exp_final));
      bad_req(0);
    end

    // Reset while a word is waiting in PUSH.
    host_init();
    hbus.idata = 16'h1357;
    hbus.load = 1'b1;
    step();
    hbus.load = 1'b0;
    step();
    hbus.idata = 16'h9BDF;
    hbus.load = 1'b1;
    step();
    check("pre_rst_wvalid", 32'(cbus.core_wvalid), 1);
    rst = 1'b1;
    step();
    check("rst_push_wvalid", 32'(cbus.core_wvalid), 0);
    check("rst_push_ack", 32'(hbus.ack), 0);
    check("rst_push_odata", 32'(hbus.odata), 0);
    rst = 1'b0;
    hbus.load = 1'b0;
    step();
    bad_req(1);
    check("rst_no_final", 32'(n_final), 32'(exp_final));

    check("err_total", 32'(n_err), 32'(exp_err));
    check("word_count", 32'(got_words.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
      check("core_word", got_words[i], exp_words[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fugue_host_if.md
Name: fugue_host_if

Overview:
Device-side responder for the host init/load/fetch/ack command protocol used by the hash benches. It accepts 16-bit message halfwords from the host and packs them into 32-bit words for the Fugue hash core. It triggers finalization and returns the 256-bit digest to the host as 16-bit halfwords. It sits between the chip pins and the hash core inside the top level.

Parameters:
IOSIZE, 16, host data bus width (halfword)
WORDSIZE, 32, core message word width; must equal 2*IOSIZE
DIGEST_WORDS, 8, number of WORDSIZE digest words (256-bit digest)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
init  input  1  host: start new message (level, sampled per cycle)
load  input  1  host: idata valid, request transfer
fetch  input  1  host: request next digest halfword
idata  input  IOSIZE  host message halfword
ack  output  1  registered 1-cycle pulse per accepted load/fetch
odata  output  IOSIZE  digest halfword, valid from ack cycle until next accepted fetch
err  output  1  registered 1-cycle pulse on protocol violation
core_init  output  1  1-cycle pulse: reset core chaining state
core_wvalid  output  1  packed message word valid
core_wdata  output  WORDSIZE  packed word, first halfword in [31:16]
core_wready  input  1  core accepts word when wvalid&&wready
core_final  output  1  1-cycle pulse: message ended, finalize
core_done  input  1  level: core_digest valid
core_digest  input  WORDSIZE*DIGEST_WORDS  digest, word 0 in MSBs

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; ack, err, core_init, core_wvalid, core_final = 0; odata, core_wdata = 0; halfword/fetch counters = 0. rst mid-transfer discards all partial data; no core_final is issued.
- States: IDLE, LOAD_HI, LOAD_LO, PUSH, FINAL, DRAIN.
- Accept condition for load/fetch: request high and ack==0 in that cycle. Because ack is registered, a request held high is accepted at most every other cycle. The host changes idata only after seeing ack.
- init has priority over load/fetch in every state, including PUSH, FINAL, and DRAIN. On init: pulse core_init next cycle, clear counters, go to LOAD_HI, no ack.
- IDLE: load or fetch -> err pulse, no ack (host times out). Stay IDLE.
- LOAD_HI: load accepted -> latch idata into buffer[31:16], ack, go to LOAD_LO. fetch accepted -> go to FINAL, no ack yet.
- LOAD_LO: load accepted -> buffer[15:0]=idata, drive core_wvalid with core_wdata=buffer, go to PUSH. ack is withheld until the core accepts the word, which gives the host backpressure. fetch here (odd halfword count) -> err pulse, return to IDLE.
- PUSH: hold core_wvalid/core_wdata stable until core_wready. On that cycle drop wvalid, pulse ack, go to LOAD_HI. load/fetch are ignored while in PUSH.
- load and fetch both high in LOAD_HI/LOAD_LO -> err pulse, neither accepted, state unchanged.
- FINAL: pulse core_final exactly once on entry, then wait for core_done. When core_done is seen, load halfword 0 (core_digest[255:240]) to odata, pulse ack, fetch count=1, go to DRAIN. A zero-length message (fetch straight after init) is legal.
- DRAIN: each accepted fetch -> odata = next halfword in MS-first order, ack. load -> err, ignored. After halfword 15 is acked, go to IDLE. A new message then requires init.
- Latency: load ack 1 cycle after acceptance for the high half; for the low half, 1 cycle after core_wready. Fetch ack 1 cycle after acceptance; first fetch ack 1 cycle after core_done.

Test Plan:
- rst 2 cycles, then init; load 0x0123, 0x4567 with core_wready=1 -> core_wdata=0x01234567 with wvalid for 1 cycle; two ack pulses; err never set.
- core_wready held 0 for 5 cycles after second load -> wvalid/wdata stable all 5 cycles; ack only on cycle after wready rises; host load held high gets no extra ack.
- After 2 words, fetch with core_digest=0x00010002...000F0010 (halfword k = k+1), core_done 3 cycles after core_final -> single core_final pulse; 16 acks return odata 0x0001..0x0010 in order; state returns IDLE.
- Odd count: init, load 0xAAAA, fetch -> err pulse, no ack, no core_final; subsequent load -> err (IDLE).
- init asserted during DRAIN after 4 halfwords -> core_init pulse, no ack; new loads accepted from LOAD_HI.
- rst asserted while in PUSH with wvalid high -> next cycle wvalid=0, ack=0, odata=0, state IDLE; load without init -> err.
